// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FULL  = 3'd3,
    ST_DROP  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [31:0] PC_STEP    = 32'd4;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handshake and redirect.
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [6:0]      if_opcode;
  logic            id_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
    input  imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
    output imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single outstanding imem read, one-entry instruction buffer.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_e    state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, pc_nxt_s;
  logic [31:0]     instr_r, instr_nxt_s;
  logic [XLEN-1:0] ipc_r, ipc_nxt_s;
  logic            req_r, req_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic            redir_s, consume_s, capture_s;

  assign redir_s   = bus.redirect_valid && (state_r != ST_BOOT);
  assign consume_s = (state_r == ST_FULL) && bus.id_ready && !redir_s;
  assign capture_s = (state_r == ST_WAIT) && bus.imem_rvalid && !redir_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a response landing in DROP ends the drop even if redirected again
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT:  state_nxt_s = ST_FETCH;
      ST_FETCH: if (redir_s) state_nxt_s = ST_DROP; else state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.imem_rvalid)  state_nxt_s = redir_s ? ST_FETCH : ST_FULL;
        else if (redir_s)     state_nxt_s = ST_DROP;
        else                  state_nxt_s = ST_WAIT;
      end
      ST_FULL:  if (redir_s || bus.id_ready) state_nxt_s = ST_FETCH; else state_nxt_s = ST_FULL;
      ST_DROP:  if (bus.imem_rvalid) state_nxt_s = ST_FETCH; else state_nxt_s = ST_DROP;
      default:  state_nxt_s = ST_BOOT;
    endcase
  end

  // Next values for PC, instruction buffer and the registered handshake outputs
  always_comb begin
    pc_nxt_s    = pc_r;
    instr_nxt_s = instr_r;
    ipc_nxt_s   = ipc_r;
    if (redir_s) begin
      pc_nxt_s = bus.redirect_pc & ALIGN_MASK;
    end else if (consume_s) begin
      pc_nxt_s = pc_r + XLEN'(PC_STEP);
    end else begin
      pc_nxt_s = pc_r;
    end
    if (capture_s) begin
      instr_nxt_s = bus.imem_rdata;
      ipc_nxt_s   = pc_r;
    end else begin
      instr_nxt_s = instr_r;
      ipc_nxt_s   = ipc_r;
    end
    req_nxt_s   = (state_nxt_s == ST_FETCH);
    valid_nxt_s = (state_nxt_s == ST_FULL);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RESET_PC;
      instr_r <= NOP_INSTR;
      ipc_r   <= RESET_PC;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      instr_r <= instr_nxt_s;
      ipc_r   <= ipc_nxt_s;
      req_r   <= req_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign bus.imem_req  = req_r;
  assign bus.imem_addr = pc_r;
  assign bus.if_valid  = valid_r;
  assign bus.if_instr  = instr_r;
  assign bus.if_pc     = ipc_r;
  assign bus.if_opcode = opcode_of(instr_r);

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_r, flushed_r;
  logic        flush_s;

  // A redirect in DROP discards nothing new, so it is not counted
  assign flush_s = redir_s && ((state_r == ST_FETCH) || (state_r == ST_WAIT) ||
                               (state_r == ST_FULL));

  // Performance counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_r <= 32'd0;
      flushed_r <= 32'd0;
    end else begin
      if (consume_s) fetched_r <= fetched_r + 32'd1;
      if (flush_s)   flushed_r <= flushed_r + 32'd1;
    end
  end

  assign perf_fetched = fetched_r;
  assign perf_flushed = flushed_r;
`endif

endmodule
